// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_arb_pkg
// Purpose  : Shared types and owner encodings for the SPI flash arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

    // Arbiter sequencing: wait for a request, idle the bus, own it, hand back.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GUARD   = 2'd1,
        S_GRANT   = 2'd2,
        S_RELEASE = 2'd3
    } arb_state_t;

    // Bus owner encoding as seen on owner_o; 2'b11 is never produced.
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_MB   = 2'b01;
    localparam logic [1:0] OWN_WR   = 2'b10;

endpackage : spi_arb_pkg
`default_nettype wire

// File: rtl/spi_arb_timer.sv
`default_nettype none
// ============================================================================
// Module   : spi_arb_timer
// Purpose  : Loadable up/down counter with saturation, zero and terminal
//            flags; serves as guard countdown and idle-owner timeout.
// Revision : 1.0 - initial release
// ============================================================================
module spi_arb_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    input  logic [CNT_W-1:0] term_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             term
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority, then clear, then count; both directions saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end else if (dec) begin
            if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign zero = (r_cnt == '0);
    assign term = (r_cnt == term_val);

endmodule : spi_arb_timer
`default_nettype wire

// File: rtl/spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_arbiter
// Purpose  : Hands the configuration-flash SPI bus to either the MicroBlaze
//            or the White Rabbit master, switching only between transactions
//            with an idle guard gap in between.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter int GUARD_CYCLES = 4,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mb_req,
    output logic       mb_gnt,
    input  logic       mb_sck_i,
    input  logic       mb_mosi_i,
    input  logic       mb_ss_i,
    output logic       mb_miso_o,
    input  logic       wr_req,
    output logic       wr_gnt,
    input  logic       wr_sck_i,
    input  logic       wr_mosi_i,
    input  logic       wr_ss_i,
    output logic       wr_miso_o,
    output logic       sck_o,
    output logic       mosi_o,
    output logic       ss_o,
    input  logic       miso_i,
    output logic [1:0] owner_o,
    output logic       timeout_o
);

    localparam logic [CNT_W-1:0] c_guard   = CNT_W'(GUARD_CYCLES);
    // Timeout fires on the edge where the count would reach IDLE_TIMEOUT.
    localparam logic [CNT_W-1:0] c_to_last = CNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    localparam logic             c_to_en   = (IDLE_TIMEOUT != 0);

    arb_state_t r_state, w_state_nxt;
    logic [1:0] r_pending, w_pending_nxt;
    logic [1:0] r_last, w_last_nxt;
    logic [1:0] r_owner, w_owner_nxt;
    logic       r_timeout, w_timeout_nxt;

    logic             w_load, w_clr, w_inc, w_dec;
    logic [CNT_W-1:0] w_cnt;
    logic             w_zero, w_term;

    logic w_own_req, w_own_ss, w_oth_req, w_inc_cond, w_pick_mb;

    spi_arb_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (c_guard),
        .clr      (w_clr),
        .inc      (w_inc),
        .dec      (w_dec),
        .term_val (c_to_last),
        .cnt      (w_cnt),
        .zero     (w_zero),
        .term     (w_term)
    );

    // Requests and chip select of the pending/current owner versus the other side.
    always_comb begin
        w_own_req  = (r_pending == OWN_MB) ? mb_req  : wr_req;
        w_own_ss   = (r_pending == OWN_MB) ? mb_ss_i : wr_ss_i;
        w_oth_req  = (r_pending == OWN_MB) ? wr_req  : mb_req;
        w_inc_cond = w_own_ss && w_oth_req;
        // Sole requester wins; on a tie the side that did not own last wins.
        w_pick_mb  = mb_req && (!wr_req || (r_last == OWN_WR));
    end

    // Arbitration state register; reset leaves the bus unowned with MB favoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= OWN_NONE;
            r_last    <= OWN_WR;
            r_owner   <= OWN_NONE;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_last    <= w_last_nxt;
            r_owner   <= w_owner_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state, ownership and timer control.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_last_nxt    = r_last;
        w_owner_nxt   = r_owner;
        w_timeout_nxt = 1'b0;
        w_load        = 1'b0;
        w_clr         = 1'b0;
        w_inc         = 1'b0;
        w_dec         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mb_req || wr_req) begin
                    w_pending_nxt = w_pick_mb ? OWN_MB : OWN_WR;
                    w_load        = 1'b1;
                    w_state_nxt   = S_GUARD;
                end
            end
            S_GUARD: begin
                if (!w_own_req) begin
                    w_state_nxt = S_IDLE;
                end else if (w_zero) begin
                    w_owner_nxt = r_pending;
                    w_state_nxt = S_GRANT;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_GRANT: begin
                // Both exits require the owner's SS high, so no transfer is cut.
                if (!w_own_req && w_own_ss) begin
                    w_owner_nxt = OWN_NONE;
                    w_state_nxt = S_RELEASE;
                end else if (c_to_en && w_inc_cond && w_term) begin
                    w_owner_nxt   = OWN_NONE;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_RELEASE;
                end else if (w_inc_cond) begin
                    w_inc = 1'b1;
                end else begin
                    w_clr = 1'b1;
                end
            end
            S_RELEASE: begin
                w_last_nxt  = r_pending;
                w_clr       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus steering from the registered owner only; unowned bus is parked idle.
    always_comb begin
        ss_o      = 1'b1;
        sck_o     = 1'b0;
        mosi_o    = 1'b0;
        mb_miso_o = 1'b0;
        wr_miso_o = 1'b0;
        case (r_owner)
            OWN_MB: begin
                ss_o      = mb_ss_i;
                sck_o     = mb_sck_i;
                mosi_o    = mb_mosi_i;
                mb_miso_o = miso_i;
            end
            OWN_WR: begin
                ss_o      = wr_ss_i;
                sck_o     = wr_sck_i;
                mosi_o    = wr_mosi_i;
                wr_miso_o = miso_i;
            end
            default: begin
                ss_o = 1'b1;
            end
        endcase
    end

    assign mb_gnt    = (r_owner == OWN_MB);
    assign wr_gnt    = (r_owner == OWN_WR);
    assign owner_o   = r_owner;
    assign timeout_o = r_timeout;

endmodule : spi_flash_arbiter
`default_nettype wire

// File: tb/tb_spi_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_arbiter
// Purpose  : Directed self-checking bench for spi_flash_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_flash_arbiter;

    localparam int GUARD_CYCLES = 4;
    localparam int IDLE_TIMEOUT = 8;
    localparam int CNT_W        = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mb_req, mb_gnt, mb_sck_i, mb_mosi_i, mb_ss_i, mb_miso_o;
    logic       wr_req, wr_gnt, wr_sck_i, wr_mosi_i, wr_ss_i, wr_miso_o;
    logic       sck_o, mosi_o, ss_o, miso_i, timeout_o;
    logic [1:0] owner_o;

    int n_checks = 0;
    int n_errors = 0;

    spi_flash_arbiter #(
        .GUARD_CYCLES (GUARD_CYCLES),
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mb_req    (mb_req),
        .mb_gnt    (mb_gnt),
        .mb_sck_i  (mb_sck_i),
        .mb_mosi_i (mb_mosi_i),
        .mb_ss_i   (mb_ss_i),
        .mb_miso_o (mb_miso_o),
        .wr_req    (wr_req),
        .wr_gnt    (wr_gnt),
        .wr_sck_i  (wr_sck_i),
        .wr_mosi_i (wr_mosi_i),
        .wr_ss_i   (wr_ss_i),
        .wr_miso_o (wr_miso_o),
        .sck_o     (sck_o),
        .mosi_o    (mosi_o),
        .ss_o      (ss_o),
        .miso_i    (miso_i),
        .owner_o   (owner_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count edges until the selected gnt rises (21 = never within bound);
    // quiet stays 1 only if the flash bus stayed parked while waiting.
    task automatic wait_gnt(input bit want_wr, output int n, output bit quiet);
        n     = 21;
        quiet = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (want_wr ? wr_gnt : mb_gnt) begin
                n = k;
                break;
            end
            if (ss_o !== 1'b1 || sck_o !== 1'b0) quiet = 1'b0;
        end
    endtask

    initial begin
        int  n;
        bit  quiet;
        int  bad;
        bit  cur_wr;
        bit  exp_wr;

        assert (GUARD_CYCLES >= 1 && GUARD_CYCLES < (1 << CNT_W) && IDLE_TIMEOUT < (1 << CNT_W))
            else $fatal(1, "parameter out of range for CNT_W");

        rst_n = 1'b0;
        mb_req = 1'b1; mb_sck_i = 1'b1; mb_mosi_i = 1'b1; mb_ss_i = 1'b0;
        wr_req = 1'b1; wr_sck_i = 1'b1; wr_mosi_i = 1'b1; wr_ss_i = 1'b0;
        miso_i = 1'b1;

        // Reset with both requesting and both masters driving their bus.
        #23;
        check("rst_bus", {ss_o, sck_o, mosi_o}, 3'b100);
        check("rst_gnt", {mb_gnt, wr_gnt, owner_o, timeout_o}, 5'b0);
        check("rst_miso", {mb_miso_o, wr_miso_o}, 2'b00);
        mb_sck_i = 1'b0; mb_mosi_i = 1'b0; mb_ss_i = 1'b1;
        wr_sck_i = 1'b0; wr_mosi_i = 1'b0; wr_ss_i = 1'b1;
        miso_i = 1'b0;
        rst_n = 1'b1;

        // First tie goes to MB, G+2 edges after release.
        wait_gnt(1'b0, n, quiet);
        check("first_gnt_lat", n, GUARD_CYCLES + 2);
        check("first_gnt_quiet", quiet, 1'b1);
        check("first_owner", {wr_gnt, owner_o}, 3'b001);
        mb_ss_i = 1'b0;

        // Owner bus follows combinationally; non-owner ignored.
        mb_sck_i = 1'b1; mb_mosi_i = 1'b1; #1;
        check("mux_mb_a", {ss_o, sck_o, mosi_o}, 3'b011);
        wr_ss_i = 1'b0; wr_sck_i = 1'b1; wr_mosi_i = 1'b0; mb_sck_i = 1'b0; #1;
        check("mux_mb_b", {ss_o, sck_o, mosi_o}, 3'b001);
        miso_i = 1'b1; #1;
        check("miso_hi", {mb_miso_o, wr_miso_o}, 2'b10);
        miso_i = 1'b0; #1;
        check("miso_lo", {mb_miso_o, wr_miso_o}, 2'b00);
        wr_ss_i = 1'b1; wr_sck_i = 1'b0; mb_mosi_i = 1'b0;

        // MB drops req mid-transaction: grant kept until SS rises.
        mb_req = 1'b0;
        step(3);
        check("hold_mid_txn", {mb_gnt, owner_o}, 3'b101);
        mb_ss_i = 1'b1;
        step(1);
        check("release_entry", {mb_gnt, wr_gnt, owner_o}, 4'b0);
        // RELEASE edge, then IDLE cycle, then G+2 to the WR grant.
        wait_gnt(1'b1, n, quiet);
        check("b2b_gnt_lat", n, GUARD_CYCLES + 3);
        check("b2b_quiet", quiet, 1'b1);
        check("b2b_owner", {mb_gnt, owner_o}, 3'b010);

        // WR idles with SS high while MB requests: revoked after IDLE_TIMEOUT.
        mb_req = 1'b1;
        bad = 0;
        for (int k = 0; k < IDLE_TIMEOUT - 1; k++) begin
            step(1);
            if (timeout_o !== 1'b0 || wr_gnt !== 1'b1) bad++;
        end
        check("to_before", bad, 0);
        step(1);
        check("to_pulse", {timeout_o, mb_gnt, wr_gnt, owner_o}, 5'b10000);
        step(1);
        check("to_one_cycle", timeout_o, 1'b0);
        wait_gnt(1'b0, n, quiet);
        check("to_next_lat", n, GUARD_CYCLES + 2);
        check("to_next_owner", {wr_gnt, owner_o}, 3'b001);

        // Owner inside a long transaction is never revoked.
        mb_ss_i = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (timeout_o !== 1'b0 || mb_gnt !== 1'b1) bad++;
        end
        check("no_to_ss_low", bad, 0);

        // Both keep requesting, each releasing after one transaction.
        cur_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cur_wr) begin
                wr_ss_i = 1'b1; wr_req = 1'b0; step(1); wr_req = 1'b1;
            end else begin
                mb_ss_i = 1'b1; mb_req = 1'b0; step(1); mb_req = 1'b1;
            end
            exp_wr = ~cur_wr;
            wait_gnt(exp_wr, n, quiet);
            check($sformatf("alt%0d_lat", i), n, GUARD_CYCLES + 3);
            check($sformatf("alt%0d_owner", i), {mb_gnt, wr_gnt, owner_o},
                  exp_wr ? 4'b0110 : 4'b1001);
            if (exp_wr) wr_ss_i = 1'b0; else mb_ss_i = 1'b0;
            cur_wr = exp_wr;
            step(2);
        end

        // MB owns again; release fully, then abort a request during GUARD.
        mb_ss_i = 1'b1; mb_req = 1'b0; wr_req = 1'b0;
        step(3);
        check("idle_owner", owner_o, 2'b00);
        wr_req = 1'b1;
        step(2);
        wr_req = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (mb_gnt !== 1'b0 || wr_gnt !== 1'b0 || ss_o !== 1'b1) bad++;
        end
        check("guard_abort", bad, 0);
        // Last owner is still MB, so WR wins the next tie.
        mb_req = 1'b1; wr_req = 1'b1;
        wait_gnt(1'b1, n, quiet);
        check("abort_tie_lat", n, GUARD_CYCLES + 2);
        check("abort_tie_owner", {mb_gnt, owner_o}, 3'b010);

        // Asynchronous reset in the middle of a WR transaction.
        wr_ss_i = 1'b0; #1;
        check("pre_rst_ss", ss_o, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst", {ss_o, sck_o, mb_gnt, wr_gnt, owner_o}, 6'b100000);
        #10 rst_n = 1'b1;
        mb_req = 1'b0; wr_req = 1'b0; wr_ss_i = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_spi_flash_arbiter
`default_nettype wire
